// File: rtl/raster_scan_generator.sv
// Clips one screen-space bounding box per triangle to the viewport and walks it
// row-major, emitting LANES adjacent sample points per beat with a coverage mask.
module raster_scan_generator #(
    parameter int VIEWPORT_WIDTH  = 64,
    parameter int VIEWPORT_HEIGHT = 64,
    parameter int LANES           = 4,
    parameter int COORD_WIDTH     = 10,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rstn,

    output logic                   bbox_s_ready,
    input  logic                   bbox_s_valid,
    input  logic [COORD_WIDTH-1:0] bbox_s_x_min,
    input  logic [COORD_WIDTH-1:0] bbox_s_x_max,
    input  logic [COORD_WIDTH-1:0] bbox_s_y_min,
    input  logic [COORD_WIDTH-1:0] bbox_s_y_max,
    input  logic [TAG_WIDTH-1:0]   bbox_s_tag,

    input  logic                   pixel_group_m_ready,
    output logic                   pixel_group_m_valid,
    output logic [COORD_WIDTH-1:0] pixel_group_m_x,
    output logic [COORD_WIDTH-1:0] pixel_group_m_y,
    output logic [LANES-1:0]       pixel_group_m_mask,
    output logic [TAG_WIDTH-1:0]   pixel_group_m_tag,
    output logic                   pixel_group_m_last_row,
    output logic                   pixel_group_m_last,

    output logic                   busy,
    output logic                   done
);

    // One extra bit keeps x+LANES and the signed clip comparisons from wrapping.
    localparam int CW1 = COORD_WIDTH + 1;

    localparam logic signed [CW1-1:0] X_LIM   = CW1'(VIEWPORT_WIDTH - 1);
    localparam logic signed [CW1-1:0] Y_LIM   = CW1'(VIEWPORT_HEIGHT - 1);
    localparam logic signed [CW1-1:0] LANES_S = CW1'(LANES);
    localparam logic        [CW1-1:0] ALIGN   = ~CW1'(LANES - 1);

    typedef enum logic [0:0] {
        IDLE,
        SCAN
    } state_t;

    state_t state;

    logic signed [CW1-1:0] cx0_q, cx1_q, cy1_q;
    logic signed [CW1-1:0] x_q, y_q;

    logic signed [CW1-1:0] in_x_min, in_x_max, in_y_min, in_y_max;
    logic signed [CW1-1:0] clip_x0, clip_x1, clip_y0, clip_y1;
    logic                  clip_empty;

    logic signed [CW1-1:0] sel_cx0, sel_cx1, sel_cy1;
    logic signed [CW1-1:0] nxt_x, nxt_y;
    logic [LANES-1:0]      nxt_mask;
    logic                  nxt_last_row, nxt_last;

    assign in_x_min = {bbox_s_x_min[COORD_WIDTH-1], bbox_s_x_min};
    assign in_x_max = {bbox_s_x_max[COORD_WIDTH-1], bbox_s_x_max};
    assign in_y_min = {bbox_s_y_min[COORD_WIDTH-1], bbox_s_y_min};
    assign in_y_max = {bbox_s_y_max[COORD_WIDTH-1], bbox_s_y_max};

    assign clip_x0    = in_x_min[CW1-1] ? '0 : in_x_min;
    assign clip_x1    = (in_x_max > X_LIM) ? X_LIM : in_x_max;
    assign clip_y0    = in_y_min[CW1-1] ? '0 : in_y_min;
    assign clip_y1    = (in_y_max > Y_LIM) ? Y_LIM : in_y_max;
    assign clip_empty = (clip_x0 > clip_x1) || (clip_y0 > clip_y1);

    // The same beat-decode logic serves the first beat (from the incoming box)
    // and every following beat (from the latched bounds).
    always_comb begin
        logic signed [CW1-1:0] px;
        // NOTE: every variable gets a value on every path, so no latch is inferred.
        px           = '0;
        nxt_mask     = '0;
        sel_cx0      = cx0_q;
        sel_cx1      = cx1_q;
        sel_cy1      = cy1_q;
        nxt_x        = x_q + LANES_S;
        nxt_y        = y_q;
        if (state == IDLE) begin
            sel_cx0 = clip_x0;
            sel_cx1 = clip_x1;
            sel_cy1 = clip_y1;
            nxt_x   = clip_x0 & ALIGN;
            nxt_y   = clip_y0;
        end else if (pixel_group_m_last_row) begin
            nxt_x = cx0_q & ALIGN;
            nxt_y = y_q + CW1'(1);
        end
        for (int i = 0; i < LANES; i++) begin
            px          = nxt_x + CW1'(i);
            nxt_mask[i] = (px >= sel_cx0) && (px <= sel_cx1);
        end
        nxt_last_row = (nxt_x + LANES_S) > sel_cx1;
        nxt_last     = nxt_last_row && (nxt_y == sel_cy1);
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state                  <= IDLE;
            cx0_q                  <= '0;
            cx1_q                  <= '0;
            cy1_q                  <= '0;
            x_q                    <= '0;
            y_q                    <= '0;
            pixel_group_m_valid    <= 1'b0;
            pixel_group_m_mask     <= '0;
            pixel_group_m_tag      <= '0;
            pixel_group_m_last_row <= 1'b0;
            pixel_group_m_last     <= 1'b0;
            done                   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bbox_s_valid) begin
                        if (clip_empty) begin
                            done <= 1'b1;
                        end else begin
                            state                  <= SCAN;
                            cx0_q                  <= clip_x0;
                            cx1_q                  <= clip_x1;
                            cy1_q                  <= clip_y1;
                            x_q                    <= nxt_x;
                            y_q                    <= nxt_y;
                            pixel_group_m_valid    <= 1'b1;
                            pixel_group_m_mask     <= nxt_mask;
                            pixel_group_m_tag      <= bbox_s_tag;
                            pixel_group_m_last_row <= nxt_last_row;
                            pixel_group_m_last     <= nxt_last;
                        end
                    end
                end
                SCAN: begin
                    if (pixel_group_m_ready) begin
                        if (pixel_group_m_last) begin
                            state               <= IDLE;
                            pixel_group_m_valid <= 1'b0;
                            done                <= 1'b1;
                        end else begin
                            x_q                    <= nxt_x;
                            y_q                    <= nxt_y;
                            pixel_group_m_mask     <= nxt_mask;
                            pixel_group_m_last_row <= nxt_last_row;
                            pixel_group_m_last     <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pixel_group_m_x = x_q[COORD_WIDTH-1:0];
    assign pixel_group_m_y = y_q[COORD_WIDTH-1:0];
    assign bbox_s_ready    = (state == IDLE);
    assign busy            = (state == SCAN);

endmodule

// File: tb/tb_raster_scan_generator.sv
// Directed bench for raster_scan_generator: box walk, clipping, empty box,
// backpressure, full viewport and mid-scan reset.
module tb_raster_scan_generator;

    logic       clk = 1'b0;
    logic       rstn;
    logic       bbox_s_ready;
    logic       bbox_s_valid;
    logic [9:0] bbox_s_x_min, bbox_s_x_max, bbox_s_y_min, bbox_s_y_max;
    logic [7:0] bbox_s_tag;
    logic       pixel_group_m_ready;
    logic       pixel_group_m_valid;
    logic [9:0] pixel_group_m_x, pixel_group_m_y;
    logic [3:0] pixel_group_m_mask;
    logic [7:0] pixel_group_m_tag;
    logic       pixel_group_m_last_row, pixel_group_m_last;
    logic       busy, done;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    raster_scan_generator #(
        .VIEWPORT_WIDTH (64),
        .VIEWPORT_HEIGHT(64),
        .LANES          (4),
        .COORD_WIDTH    (10),
        .TAG_WIDTH      (8)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .bbox_s_ready          (bbox_s_ready),
        .bbox_s_valid          (bbox_s_valid),
        .bbox_s_x_min          (bbox_s_x_min),
        .bbox_s_x_max          (bbox_s_x_max),
        .bbox_s_y_min          (bbox_s_y_min),
        .bbox_s_y_max          (bbox_s_y_max),
        .bbox_s_tag            (bbox_s_tag),
        .pixel_group_m_ready   (pixel_group_m_ready),
        .pixel_group_m_valid   (pixel_group_m_valid),
        .pixel_group_m_x       (pixel_group_m_x),
        .pixel_group_m_y       (pixel_group_m_y),
        .pixel_group_m_mask    (pixel_group_m_mask),
        .pixel_group_m_tag     (pixel_group_m_tag),
        .pixel_group_m_last_row(pixel_group_m_last_row),
        .pixel_group_m_last    (pixel_group_m_last),
        .busy                  (busy),
        .done                  (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a box for one cycle; on return the first beat (or done) is visible.
    task automatic send_box(input int x0, input int x1, input int y0, input int y1,
                            input logic [7:0] tag);
        check("ready_before_box", 64'(bbox_s_ready), 64'(1));
        bbox_s_valid = 1'b1;
        bbox_s_x_min = 10'(x0);
        bbox_s_x_max = 10'(x1);
        bbox_s_y_min = 10'(y0);
        bbox_s_y_max = 10'(y1);
        bbox_s_tag   = tag;
        step();
        bbox_s_valid = 1'b0;
    endtask

    task automatic check_beat(input string name, input int x, input int y,
                              input logic [3:0] mask, input logic lr, input logic last,
                              input logic [7:0] tag);
        check({name, "/valid"}, 64'(pixel_group_m_valid), 64'(1));
        check({name, "/x"}, 64'(pixel_group_m_x), 64'(x));
        check({name, "/y"}, 64'(pixel_group_m_y), 64'(y));
        check({name, "/mask"}, 64'(pixel_group_m_mask), 64'(mask));
        check({name, "/last_row"}, 64'(pixel_group_m_last_row), 64'(lr));
        check({name, "/last"}, 64'(pixel_group_m_last), 64'(last));
        check({name, "/tag"}, 64'(pixel_group_m_tag), 64'(tag));
        check({name, "/busy"}, 64'(busy), 64'(1));
        check({name, "/ready"}, 64'(bbox_s_ready), 64'(0));
    endtask

    task automatic expect_beat(input string name, input int x, input int y,
                               input logic [3:0] mask, input logic lr, input logic last,
                               input logic [7:0] tag);
        check_beat(name, x, y, mask, lr, last, tag);
        step();
    endtask

    // Called the cycle after the final handshake.
    task automatic expect_retire(input string name);
        check({name, "/done"}, 64'(done), 64'(1));
        check({name, "/valid_off"}, 64'(pixel_group_m_valid), 64'(0));
        check({name, "/busy_off"}, 64'(busy), 64'(0));
        check({name, "/ready_on"}, 64'(bbox_s_ready), 64'(1));
        step();
        check({name, "/done_pulse"}, 64'(done), 64'(0));
        check({name, "/idle_valid"}, 64'(pixel_group_m_valid), 64'(0));
    endtask

    initial begin
        rstn                = 1'b0;
        bbox_s_valid        = 1'b0;
        bbox_s_x_min        = '0;
        bbox_s_x_max        = '0;
        bbox_s_y_min        = '0;
        bbox_s_y_max        = '0;
        bbox_s_tag          = '0;
        pixel_group_m_ready = 1'b1;
        step();
        step();
        check("rst/valid", 64'(pixel_group_m_valid), 64'(0));
        check("rst/outs", 64'({pixel_group_m_x, pixel_group_m_y, pixel_group_m_mask,
                               pixel_group_m_tag, pixel_group_m_last_row, pixel_group_m_last}),
              64'(0));
        check("rst/done", 64'(done), 64'(0));
        check("rst/busy", 64'(busy), 64'(0));
        check("rst/ready", 64'(bbox_s_ready), 64'(1));
        rstn = 1'b1;
        step();

        // Basic walk with a 3-cycle stall on the second beat.
        send_box(5, 10, 2, 3, 8'h3C);
        expect_beat("b1", 4, 2, 4'b1110, 1'b0, 1'b0, 8'h3C);
        pixel_group_m_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_beat("stall", 8, 2, 4'b0111, 1'b1, 1'b0, 8'h3C);
            step();
        end
        pixel_group_m_ready = 1'b1;
        expect_beat("b2", 8, 2, 4'b0111, 1'b1, 1'b0, 8'h3C);
        expect_beat("b3", 4, 3, 4'b1110, 1'b0, 1'b0, 8'h3C);
        expect_beat("b4", 8, 3, 4'b0111, 1'b1, 1'b1, 8'h3C);
        expect_retire("basic");

        // Negative x and y beyond the bottom edge get clipped.
        send_box(-3, 2, 62, 70, 8'hA5);
        expect_beat("clip1", 0, 62, 4'b0111, 1'b1, 1'b0, 8'hA5);
        expect_beat("clip2", 0, 63, 4'b0111, 1'b1, 1'b1, 8'hA5);
        expect_retire("clip");

        // Box entirely right of the viewport: no beats, immediate done.
        send_box(70, 80, 0, 5, 8'h5A);
        check("empty/valid", 64'(pixel_group_m_valid), 64'(0));
        check("empty/busy", 64'(busy), 64'(0));
        check("empty/ready", 64'(bbox_s_ready), 64'(1));
        check("empty/done", 64'(done), 64'(1));
        step();
        check("empty/done_pulse", 64'(done), 64'(0));
        check("empty/no_beat", 64'(pixel_group_m_valid), 64'(0));

        // Full viewport: x,y,mask,last_row,last,busy,valid packed per beat.
        send_box(0, 63, 0, 63, 8'h77);
        for (int b = 0; b < 1024; b++) begin
            logic [9:0] ex, ey;
            ex = 10'((b % 16) * 4);
            ey = 10'(b / 16);
            check("full/beat",
                  64'({pixel_group_m_x, pixel_group_m_y, pixel_group_m_mask,
                       pixel_group_m_last_row, pixel_group_m_last, busy, pixel_group_m_valid}),
                  64'({ex, ey, 4'b1111, (ex == 10'd60), (b == 1023), 1'b1, 1'b1}));
            step();
        end
        expect_retire("full");

        // Reset after two beats abandons the box without a done pulse.
        send_box(5, 10, 2, 3, 8'h11);
        expect_beat("r1", 4, 2, 4'b1110, 1'b0, 1'b0, 8'h11);
        expect_beat("r2", 8, 2, 4'b0111, 1'b1, 1'b0, 8'h11);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("mrst/valid", 64'(pixel_group_m_valid), 64'(0));
        check("mrst/busy", 64'(busy), 64'(0));
        check("mrst/done", 64'(done), 64'(0));
        check("mrst/ready", 64'(bbox_s_ready), 64'(1));
        step();
        check("mrst/no_done", 64'(done), 64'(0));
        check("mrst/still_idle", 64'(pixel_group_m_valid), 64'(0));
        send_box(20, 27, 5, 5, 8'h22);
        expect_beat("n1", 20, 5, 4'b1111, 1'b0, 1'b0, 8'h22);
        expect_beat("n2", 24, 5, 4'b1111, 1'b1, 1'b1, 8'h22);
        expect_retire("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
